// File: rtl/ula_ar_seq.sv
// ula_ar_seq -- registered arithmetic unit for the execute stage.
//
// The control unit launches an operation with START and waits for DONE.
// Single-cycle operations (add/subtract family) pass IDLE -> EXEC -> FIN.
// Multiply passes IDLE -> MUL -> FIN. Multiply runs as a shift-add
// iteration with one partial product per cycle.
// RESU and the O/C/S/Z flags are written only in FIN, or cleared on reset.
//
// Optional feature: define ULA_AR_MUL_EN to build the iterative multiplier
// (opcode 01000). When the macro is undefined, 01000 is treated as an
// illegal opcode.
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RST          synchronous active-high reset (also aborts a multiply)
//   START        launch request, sampled only in IDLE
//   A, B, OP     operands and opcode, captured on an accepted START
//   RESU         result register, holds until the next DONE
//   O, C, S, Z   overflow / carry-borrow / sign / zero flags
//   BUSY         high in EXEC, MUL and FIN
//   DONE         one-cycle pulse when RESU and the flags update
//   ILL          high together with DONE for an unsupported opcode
module ula_ar_seq #(
    parameter int BITS  = 16,
    parameter int CNT_W = $clog2(BITS) + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic [4:0]      OP,
    output logic [BITS-1:0] RESU,
    output logic            O,
    output logic            C,
    output logic            S,
    output logic            Z,
    output logic            BUSY,
    output logic            DONE,
    output logic            ILL
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00001;
    localparam logic [4:0] OP_INC  = 5'b00011;
    localparam logic [4:0] OP_SUBD = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_DEC  = 5'b00110;
    localparam logic [4:0] OP_ADC  = 5'b01001;
    localparam logic [4:0] OP_SBB  = 5'b01010;

`ifdef ULA_AR_MUL_EN
    localparam logic [4:0] OP_MUL  = 5'b01000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        FIN  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FIN  = 2'd3
    } state_t;
`endif

    state_t            state_r;
    state_t            state_nx_s;

    // Operands captured at START acceptance
    logic [BITS-1:0]   a_r;
    logic [BITS-1:0]   b_r;
    logic [4:0]        op_r;
    logic              cin_r;

    // Result and flags waiting for the FIN commit
    logic [BITS-1:0]   res_r;
    logic              pend_o_r;
    logic              pend_c_r;
    logic              pend_ill_r;

    // Architectural outputs
    logic [BITS-1:0]   resu_r;
    logic              o_r;
    logic              c_r;
    logic              s_r;
    logic              z_r;
    logic              busy_r;
    logic              done_r;
    logic              ill_r;

    // Adder controls
    logic              sub_s;
    logic              legal_s;
    logic              cin_s;
    logic [BITS-1:0]   y_s;
    logic [BITS-1:0]   y_eff_s;
    logic [BITS:0]     sum_s;
    logic              c_flag_s;
    logic              o_flag_s;

`ifdef ULA_AR_MUL_EN
    logic [2*BITS-1:0] mcand_r;
    logic [BITS-1:0]   mplier_r;
    logic [2*BITS-1:0] prod_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              mul_last_s;

    // The final MUL cycle (count == BITS) only packages the product
    assign mul_last_s = (cnt_r == CNT_W'(BITS));
`endif

    assign RESU = resu_r;
    assign O    = o_r;
    assign C    = c_r;
    assign S    = s_r;
    assign Z    = z_r;
    assign BUSY = busy_r;
    assign DONE = done_r;
    assign ILL  = ill_r;

    // Opcode decode into one shared adder.
    // Subtraction is A + ~y + cin, and borrow is the inverted carry.
    always_comb begin
        sub_s   = 1'b0;
        legal_s = 1'b1;
        cin_s   = 1'b0;
        y_s     = {BITS{1'b0}};
        case (op_r)
            OP_ADD:  begin y_s = b_r;                             cin_s = 1'b0;   end
            OP_ADDI: begin y_s = b_r;                             cin_s = 1'b1;   end
            OP_INC:  begin y_s = {BITS{1'b0}};                    cin_s = 1'b1;   end
            OP_ADC:  begin y_s = b_r;                             cin_s = cin_r;  end
            OP_SUBD: begin y_s = b_r;                sub_s = 1'b1; cin_s = 1'b0;   end
            OP_SUB:  begin y_s = b_r;                sub_s = 1'b1; cin_s = 1'b1;   end
            OP_DEC:  begin y_s = {{(BITS-1){1'b0}}, 1'b1}; sub_s = 1'b1; cin_s = 1'b1; end
            OP_SBB:  begin y_s = b_r;                sub_s = 1'b1; cin_s = ~cin_r; end
            default: begin legal_s = 1'b0; end
        endcase

        if (sub_s) begin
            y_eff_s = ~y_s;
        end else begin
            y_eff_s = y_s;
        end

        sum_s = {1'b0, a_r} + {1'b0, y_eff_s} + {{BITS{1'b0}}, cin_s};

        if (sub_s) begin
            c_flag_s = ~sum_s[BITS];
        end else begin
            c_flag_s = sum_s[BITS];
        end

        // Overflow: the effective operands have the same sign, and the result sign differs
        o_flag_s = (a_r[BITS-1] == y_eff_s[BITS-1]) && (sum_s[BITS-1] != a_r[BITS-1]);
    end

    // Next-state logic for the sequencer
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (START) begin
`ifdef ULA_AR_MUL_EN
                    if (OP == OP_MUL) begin
                        state_nx_s = MUL;
                    end else begin
                        state_nx_s = EXEC;
                    end
`else
                    state_nx_s = EXEC;
`endif
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EXEC: state_nx_s = FIN;
`ifdef ULA_AR_MUL_EN
            MUL: begin
                if (mul_last_s) begin
                    state_nx_s = FIN;
                end else begin
                    state_nx_s = MUL;
                end
            end
`endif
            FIN:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register plus the BUSY/DONE/ILL status outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ill_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            done_r  <= (state_r == FIN);
            ill_r   <= (state_r == FIN) && pend_ill_r;
        end
    end

    // Operand capture, execution, and the FIN commit of RESU and the flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_r        <= {BITS{1'b0}};
            b_r        <= {BITS{1'b0}};
            op_r       <= 5'b00000;
            cin_r      <= 1'b0;
            res_r      <= {BITS{1'b0}};
            pend_o_r   <= 1'b0;
            pend_c_r   <= 1'b0;
            pend_ill_r <= 1'b0;
            resu_r     <= {BITS{1'b0}};
            o_r        <= 1'b0;
            c_r        <= 1'b0;
            s_r        <= 1'b0;
            z_r        <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (START) begin
                        a_r   <= A;
                        b_r   <= B;
                        op_r  <= OP;
                        cin_r <= c_r;
                    end
                end
                EXEC: begin
                    if (legal_s) begin
                        res_r    <= sum_s[BITS-1:0];
                        pend_o_r <= o_flag_s;
                        pend_c_r <= c_flag_s;
                    end else begin
                        res_r    <= {BITS{1'b0}};
                        pend_o_r <= 1'b0;
                        pend_c_r <= 1'b0;
                    end
                    pend_ill_r <= ~legal_s;
                end
`ifdef ULA_AR_MUL_EN
                MUL: begin
                    if (mul_last_s) begin
                        res_r      <= prod_r[BITS-1:0];
                        pend_o_r   <= |prod_r[2*BITS-1:BITS];
                        pend_c_r   <= |prod_r[2*BITS-1:BITS];
                        pend_ill_r <= 1'b0;
                    end
                end
`endif
                FIN: begin
                    resu_r <= res_r;
                    o_r    <= pend_o_r;
                    c_r    <= pend_c_r;
                    s_r    <= res_r[BITS-1];
                    z_r    <= (res_r == {BITS{1'b0}});
                end
                default: begin
                    res_r <= res_r;
                end
            endcase
        end
    end

`ifdef ULA_AR_MUL_EN
    // Shift-add multiplier: one multiplier bit per cycle, then a final packaging cycle
    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand_r  <= {(2*BITS){1'b0}};
            mplier_r <= {BITS{1'b0}};
            prod_r   <= {(2*BITS){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (START) begin
                        mcand_r  <= {{BITS{1'b0}}, A};
                        mplier_r <= B;
                        prod_r   <= {(2*BITS){1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                    end
                end
                MUL: begin
                    if (!mul_last_s) begin
                        if (mplier_r[0]) begin
                            prod_r <= prod_r + mcand_r;
                        end
                        mcand_r  <= {mcand_r[2*BITS-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[BITS-1:1]};
                        cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ula_ar_seq.sv
module tb_ula_ar_seq;

    localparam int BITS = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic            START;
    logic [BITS-1:0] A;
    logic [BITS-1:0] B;
    logic [4:0]      OP;
    logic [BITS-1:0] RESU;
    logic            O;
    logic            C;
    logic            S;
    logic            Z;
    logic            BUSY;
    logic            DONE;
    logic            ILL;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [4:0]      op;
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [BITS-1:0] res;
        logic [3:0]      ocsz;
        logic            ill;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    always #5 CLK = ~CLK;

    ula_ar_seq #(.BITS(BITS)) dut (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .OP(OP),
        .RESU(RESU), .O(O), .C(C), .S(S), .Z(Z),
        .BUSY(BUSY), .DONE(DONE), .ILL(ILL)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Launch one op, scramble the inputs after acceptance, and wait for DONE (bounded)
    task automatic run_op(input logic [4:0] op, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                          input int exp_lat, input string tag);
        int lat;
        @(negedge CLK);
        START = 1'b1; A = a; B = b; OP = op;
        @(posedge CLK); #1;
        START = 1'b0; A = ~a; B = ~b; OP = 5'b11111;
        check({tag, " busy"}, 32'(BUSY), 32'd1);
        check({tag, " done low"}, 32'(DONE), 32'd0);
        lat = 0;
        while (DONE !== 1'b1 && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_out(input string tag, input logic [BITS-1:0] res, input logic [3:0] ocsz,
                             input logic ill);
        check({tag, " resu"}, 32'(RESU), 32'(res));
        check({tag, " ocsz"}, 32'({O, C, S, Z}), 32'(ocsz));
        check({tag, " ill"}, 32'(ILL), 32'(ill));
        check({tag, " idle"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        int nd;

        tbl[0]  = '{5'b00000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010, 1'b0}; // ADD overflow
        tbl[1]  = '{5'b00000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 1'b0}; // ADD carry, zero
        tbl[2]  = '{5'b00000, 16'hFFFF, 16'h0002, 16'h0001, 4'b0100, 1'b0}; // ADD carry
        tbl[3]  = '{5'b01001, 16'h0000, 16'h0000, 16'h0001, 4'b0000, 1'b0}; // ADC with C=1
        tbl[4]  = '{5'b00101, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 1'b0}; // SUB borrow
        tbl[5]  = '{5'b01010, 16'h0005, 16'h0001, 16'h0003, 4'b0000, 1'b0}; // SBB with C=1
        tbl[6]  = '{5'b00001, 16'h0001, 16'h0002, 16'h0004, 4'b0000, 1'b0}; // ADDI
        tbl[7]  = '{5'b00011, 16'h7FFF, 16'h1234, 16'h8000, 4'b1010, 1'b0}; // INC overflow
        tbl[8]  = '{5'b00011, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101, 1'b0}; // INC wrap
        tbl[9]  = '{5'b00110, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110, 1'b0}; // DEC borrow
        tbl[10] = '{5'b00110, 16'h8000, 16'h0000, 16'h7FFF, 4'b1000, 1'b0}; // DEC overflow
        tbl[11] = '{5'b00100, 16'h0005, 16'h0003, 16'h0001, 4'b0000, 1'b0}; // SUBD
        tbl[12] = '{5'b00100, 16'h0003, 16'h0003, 16'hFFFF, 4'b0110, 1'b0}; // SUBD borrow
        tbl[13] = '{5'b00101, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000, 1'b0}; // SUB overflow
        tbl[14] = '{5'b01001, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101, 1'b0}; // ADC with C=0
        tbl[15] = '{5'b01010, 16'h0005, 16'h0005, 16'hFFFF, 4'b0110, 1'b0}; // SBB with C=1
        tbl[16] = '{5'b01010, 16'h0000, 16'hFFFF, 16'h0000, 4'b0101, 1'b0}; // SBB full borrow
        tbl[17] = '{5'b11111, 16'h1234, 16'h5678, 16'h0000, 4'b0001, 1'b1}; // illegal
        tbl[18] = '{5'b01001, 16'h0001, 16'h0001, 16'h0002, 4'b0000, 1'b0}; // ADC, C cleared by ILL
        tbl[19] = '{5'b00010, 16'h0001, 16'h0001, 16'h0000, 4'b0001, 1'b1}; // illegal gap
        tbl[20] = '{5'b00111, 16'h0001, 16'h0001, 16'h0000, 4'b0001, 1'b1}; // illegal gap
        tbl[21] = '{5'b00000, 16'h8000, 16'h8000, 16'h0000, 4'b1101, 1'b0}; // ADD neg overflow
        tbl[22] = '{5'b00101, 16'h7FFF, 16'hFFFF, 16'h8000, 4'b1110, 1'b0}; // SUB overflow+borrow

        // Reset for two cycles
        RST = 1'b1; START = 1'b0; A = '0; B = '0; OP = 5'b00000;
        repeat (2) @(posedge CLK);
        #1;
        check_out("reset", 16'h0000, 4'b0001, 1'b0);
        check("reset done", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Table of single-cycle ops, launched back to back
        for (int i = 0; i < NV; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 2, $sformatf("v%0d", i));
            check_out($sformatf("v%0d", i), tbl[i].res, tbl[i].ocsz, tbl[i].ill);
        end

        // START held through EXEC and FIN is ignored: exactly one DONE
        @(negedge CLK);
        START = 1'b1; A = 16'h0003; B = 16'h0004; OP = 5'b00000;
        @(posedge CLK); #1;
        A = 16'h1111; B = 16'h0001; OP = 5'b00101;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        START = 1'b0;
        nd = (DONE === 1'b1) ? 1 : 0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) nd++;
        end
        check("busy start done count", 32'(nd), 32'd1);
        check("busy start resu", 32'(RESU), 32'h0007);

`ifdef ULA_AR_MUL_EN
        run_op(5'b01000, 16'h0100, 16'h0101, 18, "mul1");
        check_out("mul1", 16'h0100, 4'b1100, 1'b0);
        run_op(5'b01000, 16'h00FF, 16'h0003, 18, "mul2");
        check_out("mul2", 16'h02FD, 4'b0000, 1'b0);
        run_op(5'b01000, 16'hFFFF, 16'hFFFF, 18, "mul3");
        check_out("mul3", 16'h0001, 4'b1100, 1'b0);

        // START pulses during a multiply are ignored
        @(negedge CLK);
        START = 1'b1; A = 16'h0002; B = 16'h0003; OP = 5'b01000;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        START = 1'b1; A = 16'h0009; B = 16'h0009; OP = 5'b00000;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        nd = 0;
        repeat (30) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) nd++;
        end
        check("mul busy done count", 32'(nd), 32'd1);
        check("mul busy resu", 32'(RESU), 32'h0006);

        // Reset at multiply cycle 5 aborts without DONE
        run_op(5'b00000, 16'h7FFF, 16'h0001, 2, "pre mul abort");
        @(negedge CLK);
        START = 1'b1; A = 16'h0100; B = 16'h0101; OP = 5'b01000;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_out("mul abort", 16'h0000, 4'b0001, 1'b0);
        check("mul abort done", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        nd = 0;
        repeat (25) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) nd++;
        end
        check("mul abort no done", 32'(nd), 32'd0);
        check("mul abort ocsz", 32'({O, C, S, Z}), 32'h1);
`else
        // Multiply not built: 01000 behaves as illegal
        run_op(5'b01000, 16'h0100, 16'h0101, 2, "mul ill");
        check_out("mul ill", 16'h0000, 4'b0001, 1'b1);
`endif

        // Reset during EXEC aborts a single-cycle op
        run_op(5'b00000, 16'h7FFF, 16'h0001, 2, "pre abort");
        check_out("pre abort", 16'h8000, 4'b1010, 1'b0);
        @(negedge CLK);
        START = 1'b1; A = 16'h0001; B = 16'h0001; OP = 5'b00000;
        @(posedge CLK); #1;
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_out("exec abort", 16'h0000, 4'b0001, 1'b0);
        check("exec abort done", 32'(DONE), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        nd = 0;
        repeat (4) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) nd++;
        end
        check("exec abort no done", 32'(nd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
